uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 71 +++++++
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ==========================================================================
// uart_pkg : shared UART widths, baud constants and capture-FSM state type
// Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

   localparam int UART_DW           = 8;
   localparam int UART_CLK_HZ       = 50_000_000;
   localparam int UART_BAUD         = 115_200;
   localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;
   localparam int UART_OVF_CNT_W    = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } rx_cap_state_t;

   // Saturating increment used by the dropped-byte counter.
   function automatic logic [UART_OVF_CNT_W-1:0] sat_inc(input logic [UART_OVF_CNT_W-1:0] v);
      return (v == {UART_OVF_CNT_W{1'b1}}) ? v : v + UART_OVF_CNT_W'(1);
   endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ==========================================================================
// uart_sync_fifo : single-clock FWFT FIFO, storage + wrapping pointers
// Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                       clk_50m,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DW-1:0]              din,
   input  logic                       pop,
   output logic [DW-1:0]              dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_lw = $clog2(DEPTH+1);
   localparam logic [c_lw-1:0] c_full_level = c_lw'(DEPTH);

   logic [DW-1:0]   r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_lw-1:0] r_level;
   logic            w_do_push;
   logic            w_do_pop;

   // A push at full is still accepted when a pop frees the head slot this cycle.
   assign w_do_pop  = pop && (r_level != '0);
   assign w_do_push = push && ((r_level != c_full_level) || w_do_pop);

   always_ff @(posedge clk_50m) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_level <= r_level + c_lw'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_level <= r_level - c_lw'(1);
         end
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign empty = (r_level == '0);
   assign full  = (r_level == c_full_level);
   assign level = r_level;

endmodule : uart_sync_fifo

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ==========================================================================
// uart_rx_fifo : receiver byte-ready handshake feeding a FIFO, overflow flags
// Option: UART_RX_OVF_COUNT_EN adds a saturating dropped-byte counter. Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DW    = UART_DW
) (
   input  logic                       clk_50m,
   input  logic                       rst,
   input  logic                       rx_rdy,
   input  logic [DW-1:0]              rx_dout,
   output logic                       rdy_clr,
   input  logic                       rd_en,
   output logic [DW-1:0]              rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       ovf,
   input  logic                       ovf_clr,
   output logic [7:0]                 ovf_count
);

   rx_cap_state_t r_state;
   logic          r_rdy_clr;
   logic          r_ovf;
   logic          w_push;
   logic          w_drop;
   logic          w_full;

   assign w_push = (r_state == IDLE) && rx_rdy;
   assign w_drop = w_push && w_full && !rd_en;

   // rdy_clr is registered alongside the state so it tracks ACK exactly.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rdy_clr <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (rx_rdy) begin
                  r_state   <= ACK;
                  r_rdy_clr <= 1'b1;
               end
            end
            ACK: begin
               if (!rx_rdy) begin
                  r_state   <= IDLE;
                  r_rdy_clr <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_rdy_clr <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

`ifdef UART_RX_OVF_COUNT_EN
   logic [7:0] r_ovf_count;

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         r_ovf_count <= '0;
      end else if (w_drop) begin
         r_ovf_count <= sat_inc(r_ovf_count);
      end else if (ovf_clr) begin
         r_ovf_count <= '0;
      end
   end

   assign ovf_count = r_ovf_count;
`else
   assign ovf_count = 8'd0;
`endif

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk_50m (clk_50m),
      .rst     (rst),
      .push    (w_push),
      .din     (rx_dout),
      .pop     (rd_en),
      .dout    (rd_data),
      .empty   (empty),
      .full    (w_full),
      .level   (level)
   );

   assign full    = w_full;
   assign rdy_clr = r_rdy_clr;
   assign ovf     = r_ovf;

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ==========================================================================
// tb_uart_rx_fifo : scoreboard bench for the receiver-side FIFO
// Rev 1.0
// ==========================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk_50m = 1'b0;
   logic          rst     = 1'b1;
   logic          rx_rdy  = 1'b0;
   logic [DW-1:0] rx_dout = '0;
   logic          rd_en   = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          rdy_clr;
   logic [DW-1:0] rd_data;
   logic          empty;
   logic          full;
   logic [LW-1:0] level;
   logic          ovf;
   logic [7:0]    ovf_count;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] model_q[$];
   int            exp_cnt = 0;
   logic          exp_ovf = 1'b0;

   uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .rx_rdy    (rx_rdy),
      .rx_dout   (rx_dout),
      .rdy_clr   (rdy_clr),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .level     (level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .ovf_count (ovf_count)
   );

   always #10 clk_50m = ~clk_50m;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_count_out();
`ifdef UART_RX_OVF_COUNT_EN
      return 8'(exp_cnt);
`else
      return 8'd0;
`endif
   endfunction

   // Full receiver handshake; caller is at a negedge. Updates the scoreboard.
   task automatic send_byte(input logic [DW-1:0] b, input logic clr);
      int t;
      logic drop;
      drop    = (model_q.size() == DEPTH);
      rx_dout = b;
      rx_rdy  = 1'b1;
      ovf_clr = clr;
      @(negedge clk_50m);
      ovf_clr = 1'b0;
      if (drop) begin
         exp_ovf = 1'b1;
         if (exp_cnt < 255) exp_cnt++;
      end else begin
         model_q.push_back(b);
         if (clr) exp_ovf = 1'b0;
      end
      t = 0;
      while (rdy_clr !== 1'b1 && t < 8) begin @(negedge clk_50m); t++; end
      n_tests++;
      if (rdy_clr !== 1'b1) begin
         n_fail++; $display("FAIL send_rdy_clr_high byte=%h: rdy_clr=%b required 1", b, rdy_clr);
      end
      rx_rdy = 1'b0;
      t = 0;
      while (rdy_clr !== 1'b0 && t < 8) begin @(negedge clk_50m); t++; end
      n_tests++;
      if (rdy_clr !== 1'b0) begin
         n_fail++; $display("FAIL send_rdy_clr_low byte=%h: rdy_clr=%b required 0", b, rdy_clr);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [DW-1:0] exp;
      n_tests++;
      if (model_q.size() == 0) begin
         n_fail++; $display("FAIL %s: scoreboard empty, rd_data=%h", tag, rd_data);
      end else begin
         exp = model_q.pop_front();
         if (rd_data !== exp) begin
            n_fail++; $display("FAIL %s: rd_data=%h required %h", tag, rd_data, exp);
         end
      end
      rd_en = 1'b1;
      @(negedge clk_50m);
      rd_en = 1'b0;
   endtask

   task automatic check_level(input string tag, input int exp_lvl);
      n_tests++;
      if (level !== LW'(exp_lvl) || empty !== (exp_lvl == 0) || full !== (exp_lvl == DEPTH)) begin
         n_fail++;
         $display("FAIL %s: level=%0d empty=%b full=%b required level=%0d", tag, level, empty, full, exp_lvl);
      end
   endtask

   task automatic check_ovf(input string tag);
      n_tests++;
      if (ovf !== exp_ovf || ovf_count !== exp_count_out()) begin
         n_fail++;
         $display("FAIL %s: ovf=%b ovf_count=%0d required ovf=%b ovf_count=%0d", tag, ovf, ovf_count, exp_ovf, exp_count_out());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_50m);
      check_level("reset_level", 0);
      check_ovf("reset_ovf");
      n_tests++;
      if (rdy_clr !== 1'b0) begin
         n_fail++; $display("FAIL reset_rdy_clr: rdy_clr=%b required 0", rdy_clr);
      end
      rst = 1'b0;
      @(negedge clk_50m);
   endtask

   task automatic test_single_byte();
      int hi;
      rx_dout = 8'hA5;
      rx_rdy  = 1'b1;
      @(negedge clk_50m);
      model_q.push_back(8'hA5);
      n_tests++;
      if (rd_data !== 8'hA5 || rdy_clr !== 1'b1) begin
         n_fail++; $display("FAIL single_capture: rd_data=%h rdy_clr=%b required A5/1", rd_data, rdy_clr);
      end
      check_level("single_level", 1);
      hi = 0;
      while (rdy_clr === 1'b1 && hi < 6) begin
         hi++;
         if (hi == 2) rx_rdy = 1'b0;
         @(negedge clk_50m);
      end
      n_tests++;
      if (hi != 2) begin
         n_fail++; $display("FAIL single_rdy_clr_len: high for %0d cycles required 2", hi);
      end
      check_level("single_no_double_push", 1);
      pop_check("single_pop");
      check_level("single_drained", 0);
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
      check_level("fill_full", DEPTH);
      for (int i = 0; i < DEPTH; i++) pop_check("fill_order");
      check_level("fill_drained", 0);
   endtask

   task automatic test_empty_read();
      rd_en = 1'b1;
      @(negedge clk_50m);
      rd_en = 1'b0;
      check_level("empty_read_ignored", 0);
      send_byte(8'h3E, 1'b0);
      check_level("empty_read_then_push", 1);
      pop_check("empty_read_pop");
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
      check_ovf("ovf_before");
      send_byte(8'h55, 1'b0);
      check_level("ovf_level_kept", DEPTH);
      check_ovf("ovf_after_drop");
      send_byte(8'h56, 1'b1);
      check_ovf("ovf_clr_vs_drop");
      ovf_clr = 1'b1;
      @(negedge clk_50m);
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      exp_cnt = 0;
      check_ovf("ovf_cleared");
   endtask

   task automatic test_push_pop_full();
      int t;
      rx_dout = 8'h77;
      rx_rdy  = 1'b1;
      pop_check("pushpop_head");
      model_q.push_back(8'h77);
      check_level("pushpop_level", DEPTH);
      check_ovf("pushpop_no_ovf");
      t = 0;
      while (rdy_clr !== 1'b1 && t < 8) begin @(negedge clk_50m); t++; end
      rx_rdy = 1'b0;
      t = 0;
      while (rdy_clr !== 1'b0 && t < 8) begin @(negedge clk_50m); t++; end
      for (int i = 0; i < DEPTH; i++) pop_check("pushpop_order");
      check_level("pushpop_drained", 0);
   endtask

   task automatic test_reset_mid_ack();
      int t;
      rx_dout = 8'h3C;
      rx_rdy  = 1'b1;
      @(negedge clk_50m);
      #3 rst = 1'b1;
      #1;
      model_q.delete();
      n_tests++;
      if (rdy_clr !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_ack_rdy_clr: rdy_clr=%b required 0", rdy_clr);
      end
      check_level("rst_mid_ack_level", 0);
      @(negedge clk_50m);
      rst = 1'b0;
      @(negedge clk_50m);
      model_q.push_back(8'h3C);
      check_level("rst_recapture_level", 1);
      n_tests++;
      if (rdy_clr !== 1'b1 || rd_data !== 8'h3C) begin
         n_fail++; $display("FAIL rst_recapture: rdy_clr=%b rd_data=%h required 1/3C", rdy_clr, rd_data);
      end
      rx_rdy = 1'b0;
      t = 0;
      while (rdy_clr !== 1'b0 && t < 8) begin @(negedge clk_50m); t++; end
      pop_check("rst_recapture_pop");
   endtask

`ifdef UART_RX_OVF_COUNT_EN
   task automatic test_ovf_count_sat();
      for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
      for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b0);
      n_tests++;
      if (ovf_count !== 8'd255 || ovf !== 1'b1) begin
         n_fail++; $display("FAIL ovf_count_sat: ovf_count=%0d ovf=%b required 255/1", ovf_count, ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk_50m);
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      exp_cnt = 0;
      check_ovf("ovf_count_cleared");
      for (int i = 0; i < DEPTH; i++) pop_check("ovf_count_drain");
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_fill_drain();
      test_empty_read();
      test_overflow();
      test_push_pop_full();
      test_reset_mid_ack();
`ifdef UART_RX_OVF_COUNT_EN
      test_ovf_count_sat();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo

`default_nettype wire
